// File: rtl/rename_map_ckpt.sv
// Register rename map with lowest-index free-list allocation, intra-group bypass,
// and a circular FIFO of map checkpoints with alloc-since bitmaps for recovery.
module rename_map_ckpt #(
    parameter int WAYS     = 2,
    parameter int ARF_SIZE = 32,
    parameter int PRF_SIZE = 64,
    parameter int CP_NUM   = 4,
    localparam int AW = $clog2(ARF_SIZE),
    localparam int PW = $clog2(PRF_SIZE),
    localparam int CW = $clog2(CP_NUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WAYS-1:0]    in_dst_en,
    input  logic [WAYS*AW-1:0] in_src_l,
    input  logic [WAYS*AW-1:0] in_src_r,
    input  logic [WAYS*AW-1:0] in_dst,
    input  logic               in_ckpt,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WAYS*PW-1:0] out_psrc_l,
    output logic [WAYS*PW-1:0] out_psrc_r,
    output logic [WAYS*PW-1:0] out_pdst,
    output logic [WAYS*PW-1:0] out_pdst_old,
    output logic [CW-1:0]      out_ckpt_id,
    input  logic [WAYS-1:0]    free_en,
    input  logic [WAYS*PW-1:0] free_preg,
    input  logic               ckpt_release,
    input  logic               recover,
    input  logic [CW-1:0]      recover_id
);

    logic [PW-1:0]       map_q   [ARF_SIZE];
    logic [PW-1:0]       map_nxt [ARF_SIZE];
    logic [PW-1:0]       ckpt_map [CP_NUM][ARF_SIZE];
    logic [PRF_SIZE-1:0] ckpt_alloc [CP_NUM];
    logic [PRF_SIZE-1:0] free_q, free_nxt, alloc_mask, free_set;
    logic [PW-1:0]       pdst_new [WAYS];
    logic [WAYS-1:0]     eff;
    logic [PW:0]         free_cnt, need;
    logic [CW-1:0]       head_q, tail_q, rec_off;
    logic [CW:0]         count_q;
    logic                accept, ckpt_full, rel_eff;
    logic [WAYS*PW-1:0]  psrc_l_c, psrc_r_c, pdst_c, pdst_old_c;

    always_comb begin
        eff      = '0;
        need     = '0;
        free_cnt = '0;
        for (int i = 0; i < WAYS; i++) begin
            eff[i] = in_dst_en[i] && (in_dst[i*AW +: AW] != '0);
            need   = need + {{PW{1'b0}}, eff[i]};
        end
        for (int k = 0; k < PRF_SIZE; k++)
            free_cnt = free_cnt + {{PW{1'b0}}, free_q[k]};
    end

    assign ckpt_full = (count_q == (CW+1)'(CP_NUM));
    assign in_ready  = !recover && (free_cnt >= need) && !(in_ckpt && ckpt_full);
    assign accept    = in_valid && in_ready;
    assign rel_eff   = ckpt_release && (count_q != '0);
    assign rec_off   = recover_id - head_q;

    // Lowest free index first; earlier ways claim before later ways.
    always_comb begin
        logic [PRF_SIZE-1:0] avail;
        logic                found;
        avail      = free_q;
        alloc_mask = '0;
        for (int i = 0; i < WAYS; i++) begin
            pdst_new[i] = '0;
            found       = 1'b0;
            if (eff[i]) begin
                for (int k = 1; k < PRF_SIZE; k++) begin
                    if (!found && avail[k]) begin
                        pdst_new[i] = PW'(k);
                        found       = 1'b1;
                    end
                end
                if (found) begin
                    avail[pdst_new[i]]      = 1'b0;
                    alloc_mask[pdst_new[i]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0] sl, sr, d;
        logic [PW-1:0] psl, psr, pold;
        psrc_l_c   = '0;
        psrc_r_c   = '0;
        pdst_c     = '0;
        pdst_old_c = '0;
        map_nxt    = map_q;
        for (int i = 0; i < WAYS; i++) begin
            sl   = in_src_l[i*AW +: AW];
            sr   = in_src_r[i*AW +: AW];
            d    = in_dst[i*AW +: AW];
            psl  = map_q[sl];
            psr  = map_q[sr];
            pold = map_q[d];
            // Ascending scan so the highest older way with a match wins.
            for (int j = 0; j < WAYS; j++) begin
                if (j < i && eff[j]) begin
                    if (in_dst[j*AW +: AW] == sl) psl  = pdst_new[j];
                    if (in_dst[j*AW +: AW] == sr) psr  = pdst_new[j];
                    if (in_dst[j*AW +: AW] == d)  pold = pdst_new[j];
                end
            end
            psrc_l_c[i*PW +: PW]   = psl;
            psrc_r_c[i*PW +: PW]   = psr;
            pdst_old_c[i*PW +: PW] = pold;
            pdst_c[i*PW +: PW]     = eff[i] ? pdst_new[i] : '0;
            if (eff[i]) map_nxt[d] = pdst_new[i];
        end
    end

    always_comb begin
        free_set = '0;
        for (int i = 0; i < WAYS; i++)
            if (free_en[i]) free_set[free_preg[i*PW +: PW]] = 1'b1;
        free_set[0] = 1'b0;
        free_nxt = (free_q & ~(accept ? alloc_mask : '0)) | free_set
                 | (recover ? ckpt_alloc[recover_id] : '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < ARF_SIZE; a++) map_q[a] <= PW'(a);
            for (int k = 0; k < PRF_SIZE; k++) free_q[k] <= (k >= ARF_SIZE);
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            out_valid    <= 1'b0;
            out_psrc_l   <= '0;
            out_psrc_r   <= '0;
            out_pdst     <= '0;
            out_pdst_old <= '0;
            out_ckpt_id  <= '0;
        end else begin
            out_valid <= accept;
            free_q    <= free_nxt;
            head_q    <= head_q + CW'(rel_eff);
            if (accept) begin
                map_q        <= map_nxt;
                out_psrc_l   <= psrc_l_c;
                out_psrc_r   <= psrc_r_c;
                out_pdst     <= pdst_c;
                out_pdst_old <= pdst_old_c;
                out_ckpt_id  <= tail_q;
            end
            if (recover) begin
                map_q   <= ckpt_map[recover_id];
                tail_q  <= recover_id + CW'(1);
                count_q <= {1'b0, rec_off} + (CW+1)'(1) - (CW+1)'(rel_eff);
            end else begin
                tail_q  <= tail_q + CW'(accept && in_ckpt);
                count_q <= count_q + (CW+1)'(accept && in_ckpt) - (CW+1)'(rel_eff);
            end
        end
    end

    // Checkpoint storage needs no reset: a slot is always written when it is pushed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (accept)
                for (int c = 0; c < CP_NUM; c++) ckpt_alloc[c] <= ckpt_alloc[c] | alloc_mask;
            if (accept && in_ckpt) begin
                ckpt_map[tail_q]   <= map_nxt;
                ckpt_alloc[tail_q] <= '0;
            end
            if (recover) ckpt_alloc[recover_id] <= '0;
        end
    end

    a_recover_live: assert property (@(posedge clock) disable iff (reset)
        recover |-> ({1'b0, rec_off} < count_q));

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed bench for rename_map_ckpt: bypass, x0 handling, free-list exhaustion,
// checkpoint save/recover, FIFO full stall and reset overriding recover.
module tb_rename_map_ckpt;
    localparam int WAYS = 2;
    localparam int AW   = 5;
    localparam int PW   = 6;
    localparam int CW   = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid;
    logic [WAYS-1:0]    in_dst_en;
    logic [WAYS*AW-1:0] in_src_l, in_src_r, in_dst;
    logic               in_ckpt;
    logic               in_ready;
    logic               out_valid;
    logic [WAYS*PW-1:0] out_psrc_l, out_psrc_r, out_pdst, out_pdst_old;
    logic [CW-1:0]      out_ckpt_id;
    logic [WAYS-1:0]    free_en;
    logic [WAYS*PW-1:0] free_preg;
    logic               ckpt_release;
    logic               recover;
    logic [CW-1:0]      recover_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    rename_map_ckpt dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_dst_en(in_dst_en),
        .in_src_l(in_src_l), .in_src_r(in_src_r), .in_dst(in_dst), .in_ckpt(in_ckpt),
        .in_ready(in_ready), .out_valid(out_valid), .out_psrc_l(out_psrc_l),
        .out_psrc_r(out_psrc_r), .out_pdst(out_pdst), .out_pdst_old(out_pdst_old),
        .out_ckpt_id(out_ckpt_id), .free_en(free_en), .free_preg(free_preg),
        .ckpt_release(ckpt_release), .recover(recover), .recover_id(recover_id)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fld(input logic [WAYS*PW-1:0] v, input int w);
        return int'(v[w*PW +: PW]);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_dst_en = '0; in_src_l = '0; in_src_r = '0; in_dst = '0;
        in_ckpt = 0; free_en = '0; free_preg = '0; ckpt_release = 0;
        recover = 0; recover_id = '0;
    endtask

    task automatic set_way(input int w, input bit en, input int sl, input int sr, input int d);
        in_dst_en[w]          = en;
        in_src_l[w*AW +: AW]  = AW'(sl);
        in_src_r[w*AW +: AW]  = AW'(sr);
        in_dst[w*AW +: AW]    = AW'(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        step(); step();
        reset = 0;
        #1;
        check_val("rst_in_ready", 32'(in_ready), 1);
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_pdst", 32'(out_pdst), 0);
        check_val("rst_out_psrc_l", 32'(out_psrc_l), 0);

        // Intra-group bypass after reset
        idle(); in_valid = 1;
        set_way(0, 1, 2, 0, 1);
        set_way(1, 1, 1, 2, 1);
        step();
        check_val("byp_valid", 32'(out_valid), 1);
        check_val("byp_pdst0", fld(out_pdst, 0), 32);
        check_val("byp_old0", fld(out_pdst_old, 0), 1);
        check_val("byp_psrc_l0", fld(out_psrc_l, 0), 2);
        check_val("byp_psrc_l1", fld(out_psrc_l, 1), 32);
        check_val("byp_psrc_r1", fld(out_psrc_r, 1), 2);
        check_val("byp_pdst1", fld(out_pdst, 1), 33);
        check_val("byp_old1", fld(out_pdst_old, 1), 32);
        idle();
        step();
        check_val("one_cycle_valid", 32'(out_valid), 0);

        // dst x0 and disabled dst: no allocation
        idle(); in_valid = 1;
        set_way(0, 1, 1, 0, 0);
        set_way(1, 0, 0, 0, 3);
        step();
        check_val("x0_pdst0", fld(out_pdst, 0), 0);
        check_val("x0_pdst1", fld(out_pdst, 1), 0);
        check_val("x0_psrc_l0", fld(out_psrc_l, 0), 33);
        idle(); in_valid = 1;
        set_way(0, 1, 0, 0, 3);
        set_way(1, 1, 0, 0, 4);
        step();
        check_val("x0_next_pdst0", fld(out_pdst, 0), 34);
        check_val("x0_next_pdst1", fld(out_pdst, 1), 35);

        // Drain the rest of the spare registers (36..63)
        for (int g = 0; g < 14; g++) begin
            idle(); in_valid = 1;
            set_way(0, 1, 0, 0, 6);
            set_way(1, 1, 0, 0, 7);
            step();
            if (g == 0) check_val("drain_first", fld(out_pdst, 0), 36);
            if (g == 13) begin
                check_val("drain_last0", fld(out_pdst, 0), 62);
                check_val("drain_last1", fld(out_pdst, 1), 63);
                check_val("drain_old1", fld(out_pdst_old, 1), 61);
            end
        end

        // Empty free list stalls; free preg 1 (and preg 0, which must be ignored)
        idle(); in_valid = 1;
        set_way(0, 1, 0, 0, 8);
        free_en = 2'b11;
        free_preg = {6'd0, 6'd1};
        #1;
        check_val("empty_in_ready", 32'(in_ready), 0);
        step();
        check_val("empty_not_acc", 32'(out_valid), 0);
        free_en = '0;
        #1;
        check_val("freed_in_ready", 32'(in_ready), 1);
        step();
        check_val("freed_valid", 32'(out_valid), 1);
        check_val("freed_pdst0", fld(out_pdst, 0), 1);
        check_val("freed_pdst1", fld(out_pdst, 1), 0);

        // Release 10..13 for the checkpoint tests
        idle(); free_en = 2'b11; free_preg = {6'd11, 6'd10};
        step();
        free_preg = {6'd13, 6'd12};
        step();

        // Checkpoint, rename again, recover
        idle(); in_valid = 1; in_ckpt = 1;
        set_way(0, 1, 5, 0, 5);
        step();
        check_val("ck_pdst0", fld(out_pdst, 0), 10);
        check_val("ck_old0", fld(out_pdst_old, 0), 5);
        check_val("ck_id", 32'(out_ckpt_id), 0);
        idle(); in_valid = 1;
        set_way(0, 1, 0, 0, 5);
        step();
        check_val("ck2_pdst0", fld(out_pdst, 0), 11);
        check_val("ck2_old0", fld(out_pdst_old, 0), 10);
        idle(); recover = 1; recover_id = 2'd0;
        #1;
        check_val("rec_in_ready", 32'(in_ready), 0);
        step();
        idle(); in_valid = 1;
        set_way(0, 1, 5, 0, 9);
        step();
        check_val("rec_psrc_x5", fld(out_psrc_l, 0), 10);
        check_val("rec_refree", fld(out_pdst, 0), 11);

        // Fill the checkpoint FIFO (slot 0 already live)
        for (int c = 1; c < 4; c++) begin
            idle(); in_valid = 1; in_ckpt = 1;
            step();
            check_val("fill_id", 32'(out_ckpt_id), c);
        end
        idle(); in_valid = 1; in_ckpt = 1;
        #1;
        check_val("full_in_ready", 32'(in_ready), 0);
        step();
        check_val("full_not_acc", 32'(out_valid), 0);
        ckpt_release = 1;
        #1;
        check_val("rel_same_ready", 32'(in_ready), 0);
        step();
        ckpt_release = 0;
        #1;
        check_val("rel_next_ready", 32'(in_ready), 1);
        step();
        check_val("rel_valid", 32'(out_valid), 1);
        check_val("rel_ckpt_id", 32'(out_ckpt_id), 0);

        // Recover beats a rename group; then reset in the middle of a recover
        idle(); in_valid = 1; recover = 1; recover_id = 2'd1;
        set_way(0, 1, 0, 0, 2);
        #1;
        check_val("rec_grp_ready", 32'(in_ready), 0);
        step();
        check_val("rec_grp_valid", 32'(out_valid), 0);
        reset = 1;
        step();
        reset = 0;
        idle();
        #1;
        check_val("rst2_valid", 32'(out_valid), 0);
        check_val("rst2_ready", 32'(in_ready), 1);
        check_val("rst2_pdst", 32'(out_pdst), 0);
        in_valid = 1; in_ckpt = 1;
        set_way(0, 1, 5, 1, 5);
        set_way(1, 1, 5, 0, 1);
        step();
        check_val("rst2_psrc_l0", fld(out_psrc_l, 0), 5);
        check_val("rst2_psrc_r0", fld(out_psrc_r, 0), 1);
        check_val("rst2_pdst0", fld(out_pdst, 0), 32);
        check_val("rst2_old0", fld(out_pdst_old, 0), 5);
        check_val("rst2_psrc_l1", fld(out_psrc_l, 1), 32);
        check_val("rst2_pdst1", fld(out_pdst, 1), 33);
        check_val("rst2_old1", fld(out_pdst_old, 1), 1);
        check_val("rst2_ckpt_id", 32'(out_ckpt_id), 0);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rename_map_ckpt.md
RENAME_MAP_CKPT -- requirements
Module: rename_map_ckpt

Interface
REQ-001 Parameter WAYS, default 2, rename group width (instructions per cycle).
REQ-002 Parameter ARF_SIZE, default 32, architectural integer registers; AW = log2(ARF_SIZE).
REQ-003 Parameter PRF_SIZE, default 64, physical integer registers; PW = log2(PRF_SIZE); PRF_SIZE >= ARF_SIZE + WAYS.
REQ-004 Parameter CP_NUM, default 4, checkpoint slots; CW = log2(CP_NUM).
REQ-005 clock  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  a rename group is presented.
REQ-008 in_dst_en  in  WAYS  per-way destination write enable.
REQ-009 in_src_l / in_src_r / in_dst  in  WAYS*AW each  per-way architectural source and destination indices.
REQ-010 in_ckpt  in  1  take a checkpoint after this group.
REQ-011 in_ready  out  1  group accepted this cycle when in_valid and in_ready are both high.
REQ-012 out_valid  out  1  registered rename results valid.
REQ-013 out_psrc_l / out_psrc_r / out_pdst / out_pdst_old  out  WAYS*PW each  physical sources, new destination, previous mapping of the destination.
REQ-014 out_ckpt_id  out  CW  slot allocated by in_ckpt; valid with out_valid.
REQ-015 free_en  in  WAYS  per-way commit release enable; free_preg  in  WAYS*PW  physical registers released.
REQ-016 ckpt_release  in  1  retire the oldest live checkpoint.
REQ-017 recover  in  1  restore checkpoint recover_id (in, CW).

Function
REQ-018 The block SHALL accept a group only when the free count >= popcount(effective dst) and, if in_ckpt, a checkpoint slot is free; otherwise in_ready SHALL be low.
REQ-019 Effective dst SHALL be in_dst_en[i] with in_dst[i] != 0; arch reg 0 SHALL always read physical 0 and never be renamed.
REQ-020 Way i sources SHALL read the map, then be overridden by the new pdst of the highest-numbered way j < i with effective dst equal to that source.
REQ-021 out_pdst_old[i] SHALL apply the same intra-group bypass as sources; out_pdst for a way without effective dst SHALL be 0.
REQ-022 Physical registers SHALL be allocated lowest-free-index first, way 0 before way 1, and the map updated at the accepting edge; results SHALL appear on outputs exactly 1 cycle after acceptance.
REQ-023 out_valid SHALL be high for one cycle per accepted group and low otherwise.
REQ-024 Free list SHALL be a PRF_SIZE bitmap; free_en bits SHALL set the bit the same edge; freeing physical 0 SHALL be ignored.
REQ-025 Checkpoints SHALL be a circular FIFO of CP_NUM slots; in_ckpt SHALL snapshot the map including this group's updates into the tail slot and advance the tail.
REQ-026 Each live checkpoint SHALL hold an alloc-since bitmap, cleared at save, accumulating every physical register allocated in later groups.
REQ-027 ckpt_release SHALL advance the head; release on an empty FIFO SHALL be ignored.
REQ-028 recover SHALL restore map from slot recover_id, set free bits for its alloc-since bitmap, set tail to recover_id+1 (mod CP_NUM) keeping slot recover_id live, and force in_ready low that cycle.
REQ-029 recover SHALL take priority over a same-cycle rename group; free_en in the same cycle SHALL still apply.
REQ-030 ckpt_release with in_ckpt in the same cycle SHALL be permitted at full occupancy only after release (in_ready uses pre-release occupancy).
REQ-031 recover_id not live SHALL be a protocol violation; behaviour undefined, flagged by assertion.

Reset
REQ-032 On reset map[i] SHALL be i, free bits ARF_SIZE..PRF_SIZE-1 set, all others clear, checkpoint FIFO empty.
REQ-033 On reset out_valid SHALL be 0, all result outputs 0, in_ready 1 once reset deasserts.
REQ-034 Reset SHALL override recover, free_en and rename in the same cycle.

Verification
REQ-035 After reset, way0 dst x1 src x2, way1 src_l x1 dst x1 -> way0 pdst 32 old 1 psrc 2; way1 psrc_l 32 pdst 33 old 32.
REQ-036 Way with dst x0 -> no allocation, out_pdst 0, free count unchanged.
REQ-037 Allocate all 32 spare registers, then request 1 -> in_ready 0; free_en one reg same cycle -> accepted next cycle.
REQ-038 in_ckpt on group renaming x5->32, then rename x5->33, recover id 0 -> x5 reads 32, reg 33 free again.
REQ-039 Fill CP_NUM checkpoints -> in_ckpt stalls; ckpt_release plus in_ckpt same cycle -> accepted next cycle.
REQ-040 recover asserted with in_valid and reset mid-recover -> group not accepted; reset state as REQ-032.
